router_fsm: RTL and testbench

- Control FSM of a 1-to-3 packet router.
- Decodes the 2-bit destination address of an incoming packet and sequences header, payload and parity loading into the router's register block.
- Stalls on full or non-empty destination FIFOs, requests the internal parity check, and drives `busy` back to the packet source.
- Sits between the input port, the router register block and the three output FIFOs/synchronizer.

---
 rtl/router_fsm_pkg.sv | 22 ++
 rtl/router_fsm.sv | 128 ++++++++++++
 tb/tb_router_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1-to-3 packet router control logic.
//   state_e      : the eight control FSM states, 3-bit binary encoding
//   ADDR_*       : destination address codes carried in header bits [1:0]
package router_fsm_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// Control FSM of a 1-to-3 packet router.
// Decodes the header destination, sequences header/payload/parity loading,
// stalls on a full or non-empty destination FIFO and drives busy to the source.
// Ports:
//   clock, resetn                 : clock, asynchronous active-low reset
//   pkt_valid, data_in[1:0]       : packet strobe and header destination bits
//   fifo_full                     : selected destination FIFO full
//   fifo_empty_0..2               : per-FIFO empty flags
//   soft_reset_0..2               : per-FIFO timeout soft resets
//   parity_done, low_packet_valid : status from the register block
//   write_enb_reg .. busy         : Moore outputs decoded from the state
//   state_dbg                     : current state, for observation only
//
// Handshake: busy=1 tells the source to hold its current byte; the source may
// only advance to the next byte on a clock edge where busy=0.
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output state_e     state_dbg
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic empty_in;     // empty flag selected by the incoming header
  logic empty_addr;   // empty flag selected by the latched address
  logic soft_rst_sel; // soft reset of the latched address

  always_comb begin
    empty_in = 1'b0;
    case (data_in)
      ADDR_0:  empty_in = fifo_empty_0;
      ADDR_1:  empty_in = fifo_empty_1;
      ADDR_2:  empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
  end

  always_comb begin
    empty_addr   = 1'b0;
    soft_rst_sel = 1'b0;
    case (addr_q)
      ADDR_0: begin empty_addr = fifo_empty_0; soft_rst_sel = soft_reset_0; end
      ADDR_1: begin empty_addr = fifo_empty_1; soft_rst_sel = soft_reset_1; end
      ADDR_2: begin empty_addr = fifo_empty_2; soft_rst_sel = soft_reset_2; end
      default: begin empty_addr = 1'b0; soft_rst_sel = 1'b0; end
    endcase
  end

  // The latch follows data_in for as long as a header is offered in DECODE,
  // so it holds the destination of the packet actually accepted.
  always_comb begin
    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = data_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != ADDR_INVALID)
          state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      WAIT_TILL_EMPTY: if (empty_addr) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_d = DECODE_ADDRESS;
        else if (low_packet_valid) state_d = LOAD_PARITY;
        else                       state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
    // A timeout on the current destination abandons the packet from anywhere.
    if (soft_rst_sel) state_d = DECODE_ADDRESS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    full_state    = (state_q == FIFO_FULL_STATE);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed testbench for router_fsm. Output vectors are packed as
// {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
//  rst_int_reg, busy}.
module tb_router_fsm;
  import router_fsm_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b0, fifo_empty_1 = 1'b0, fifo_empty_2 = 1'b0;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
  logic       full_state, rst_int_reg, busy;
  state_e     state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // Hand-computed output vectors per state.
  localparam logic [7:0] V_DA  = 8'b0100_0000;
  localparam logic [7:0] V_LFD = 8'b0000_1001;
  localparam logic [7:0] V_LD  = 8'b1010_0000;
  localparam logic [7:0] V_WTE = 8'b0000_0001;
  localparam logic [7:0] V_FF  = 8'b0000_0101;
  localparam logic [7:0] V_LAF = 8'b1001_0001;
  localparam logic [7:0] V_LP  = 8'b1000_0001;
  localparam logic [7:0] V_CPE = 8'b0000_0011;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
    .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .busy(busy), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [7:0] exp_vec,
                           input state_e exp_st);
    logic [7:0] obs;
    obs = {write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
           full_state, rst_int_reg, busy};
    tests_run++;
    assert (obs === exp_vec) else begin
      tests_failed++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp_vec);
    end
    tests_run++;
    assert (state_dbg === exp_st) else begin
      tests_failed++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, exp_st);
    end
  endtask

  initial begin
    // Reset state
    #2;
    expect_st("in_reset", V_DA, DECODE_ADDRESS);
    #6 resetn = 1'b1;
    step();
    expect_st("after_reset_idle", V_DA, DECODE_ADDRESS);

    // Normal packet to address 2
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b1;
    step(); expect_st("norm_lfd", V_LFD, LOAD_FIRST_DATA);
    step(); expect_st("norm_ld", V_LD, LOAD_DATA);
    pkt_valid = 1'b0;
    step(); expect_st("norm_lp", V_LP, LOAD_PARITY);
    step(); expect_st("norm_cpe", V_CPE, CHECK_PARITY_ERROR);
    step(); expect_st("norm_da", V_DA, DECODE_ADDRESS);

    // Busy destination, then FIFO full stall and LAF branches
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step(); expect_st("busy_wte", V_WTE, WAIT_TILL_EMPTY);
    step(); expect_st("busy_wte_hold", V_WTE, WAIT_TILL_EMPTY);
    fifo_empty_2 = 1'b1;
    step(); expect_st("busy_lfd", V_LFD, LOAD_FIRST_DATA);
    step(); expect_st("stall_ld", V_LD, LOAD_DATA);
    fifo_full = 1'b1;
    step(); expect_st("stall_ff", V_FF, FIFO_FULL_STATE);
    step(); expect_st("stall_ff_hold", V_FF, FIFO_FULL_STATE);
    fifo_full = 1'b0;
    step(); expect_st("stall_laf", V_LAF, LOAD_AFTER_FULL);
    step(); expect_st("laf_to_ld", V_LD, LOAD_DATA);
    fifo_full = 1'b1;
    step(); expect_st("stall2_ff", V_FF, FIFO_FULL_STATE);
    fifo_full = 1'b0;
    step(); expect_st("stall2_laf", V_LAF, LOAD_AFTER_FULL);
    low_packet_valid = 1'b1; pkt_valid = 1'b0;
    step(); expect_st("laf_to_lp", V_LP, LOAD_PARITY);
    low_packet_valid = 1'b0;
    step(); expect_st("lp_cpe", V_CPE, CHECK_PARITY_ERROR);
    fifo_full = 1'b1;
    step(); expect_st("cpe_to_ff", V_FF, FIFO_FULL_STATE);
    fifo_full = 1'b0;
    step(); expect_st("stall3_laf", V_LAF, LOAD_AFTER_FULL);
    parity_done = 1'b1;
    step(); expect_st("laf_to_da", V_DA, DECODE_ADDRESS);
    parity_done = 1'b0;

    // Asynchronous reset in the middle of LOAD_DATA
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
    step(); expect_st("rst_lfd", V_LFD, LOAD_FIRST_DATA);
    step(); expect_st("rst_ld", V_LD, LOAD_DATA);
    resetn = 1'b0;
    #2 expect_st("rst_async", V_DA, DECODE_ADDRESS);
    pkt_valid = 1'b0;
    resetn = 1'b1;
    step(); expect_st("rst_release", V_DA, DECODE_ADDRESS);

    // Soft reset: only the latched address counts
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0;
    step(); expect_st("sr_wte", V_WTE, WAIT_TILL_EMPTY);
    soft_reset_0 = 1'b1;
    step(); expect_st("sr_other_ignored", V_WTE, WAIT_TILL_EMPTY);
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
    step(); expect_st("sr_own_da", V_DA, DECODE_ADDRESS);
    soft_reset_1 = 1'b0;

    // Soft reset overriding a normal transition (LOAD_DATA for address 1)
    fifo_empty_1 = 1'b1;
    step(); expect_st("sr2_lfd", V_LFD, LOAD_FIRST_DATA);
    step(); expect_st("sr2_ld", V_LD, LOAD_DATA);
    soft_reset_1 = 1'b1; fifo_full = 1'b1;
    step(); expect_st("sr2_override", V_DA, DECODE_ADDRESS);
    soft_reset_1 = 1'b0; fifo_full = 1'b0;

    // Invalid address with every FIFO empty
    pkt_valid = 1'b1; data_in = 2'd3;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_st("invalid_addr", V_DA, DECODE_ADDRESS);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
